// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the block-RAM round-robin arbiter.
package bram_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef logic [2:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_stage_t;

  // Advance a round-robin pointer past the winner, wrapping at n-1.
  function automatic req_id_t next_id(input req_id_t id, input int n);
    if (int'(id) >= n - 1) return '0;
    return id + req_id_t'(1);
  endfunction

endpackage

// File: rtl/bram_rr_arbiter_rr_pick.sv
// Round-robin picker: searches the request vector starting at ptr,
// wrapping modulo N, and returns a one-hot grant plus the winner index.
module rr_pick
  import bram_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  req_id_t      ptr,
  output logic [N-1:0] grant,
  output req_id_t      idx,
  output logic         any
);

  logic    hi_found;
  req_id_t hi_idx;
  logic    lo_found;
  req_id_t lo_idx;

  // Lowest request at or above ptr wins; otherwise wrap to the lowest request overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_found = 1'b1;
        lo_idx   = req_id_t'(j);
        if (req_id_t'(j) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = req_id_t'(j);
        end
      end
    end
    any = lo_found;
    idx = hi_found ? hi_idx : lo_idx;
    grant = '0;
    for (int j = 0; j < N; j++) begin
      grant[j] = lo_found && (idx == req_id_t'(j));
    end
  end

endmodule

// File: rtl/bram_rr_arbiter.sv
// Shares one simple-dual-port block RAM between NUM_REQ requesters.
// Read and write ports are arbitrated independently with round-robin
// pointers; grants are combinational, RAM-side signals are registered,
// and read data returns to the issuer two cycles after its grant.
// Optional stall counters are enabled with BRAM_ARB_STATS_EN.
module bram_rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int WID_MEM = 18,
  parameter int ADDR_W  = 12,
  parameter int NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*WID_MEM-1:0] req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [WID_MEM-1:0]         rsp_data,
  output logic [ADDR_W-1:0]          mem_raddr,
  output logic [ADDR_W-1:0]          mem_waddr,
  output logic [WID_MEM-1:0]         mem_din,
  output logic                       mem_we,
  input  logic [WID_MEM-1:0]         mem_dout,
  output logic [NUM_REQ*16-1:0]      stall_cnt
);

  logic [NUM_REQ-1:0] rd_pool;
  logic [NUM_REQ-1:0] wr_pool;
  logic [NUM_REQ-1:0] rd_grant;
  logic [NUM_REQ-1:0] wr_grant;
  req_id_t            rd_ptr;
  req_id_t            wr_ptr;
  req_id_t            rd_idx;
  req_id_t            wr_idx;
  logic               rd_any;
  logic               wr_any;
  logic [ADDR_W-1:0]  rd_addr;
  logic [ADDR_W-1:0]  wr_addr;
  logic [WID_MEM-1:0] wr_data;
  rd_stage_t          stage1;
  rd_stage_t          stage2;

  // No requester may be granted while reset is held.
  assign rd_pool = reset ? '0 : (req_valid & ~req_we);
  assign wr_pool = reset ? '0 : (req_valid & req_we);

  rr_pick #(.N(NUM_REQ)) u_rd_pick (
    .req   (rd_pool),
    .ptr   (rd_ptr),
    .grant (rd_grant),
    .idx   (rd_idx),
    .any   (rd_any)
  );

  rr_pick #(.N(NUM_REQ)) u_wr_pick (
    .req   (wr_pool),
    .ptr   (wr_ptr),
    .grant (wr_grant),
    .idx   (wr_idx),
    .any   (wr_any)
  );

  // A requester is either reading or writing, so the two grants never overlap.
  assign req_ready = rd_grant | wr_grant;

  // Route the winning requester's address and data towards the RAM registers.
  always_comb begin
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (rd_grant[j]) rd_addr = req_addr[j*ADDR_W +: ADDR_W];
      if (wr_grant[j]) begin
        wr_addr = req_addr[j*ADDR_W +: ADDR_W];
        wr_data = req_wdata[j*WID_MEM +: WID_MEM];
      end
    end
  end

  // Round-robin pointers move just past each winner and hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (rd_any) rd_ptr <= next_id(rd_idx, NUM_REQ);
      if (wr_any) wr_ptr <= next_id(wr_idx, NUM_REQ);
    end
  end

  // Write port registers; address and data hold when no write is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_din   <= '0;
    end else begin
      mem_we <= wr_any;
      if (wr_any) begin
        mem_waddr <= wr_addr;
        mem_din   <= wr_data;
      end
    end
  end

  // Read address register plus a two-deep tag pipeline matching RAM latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_raddr <= '0;
      stage1    <= '0;
      stage2    <= '0;
    end else begin
      if (rd_any) mem_raddr <= rd_addr;
      stage1.valid <= rd_any;
      stage1.id    <= rd_idx;
      stage2       <= stage1;
    end
  end

  // Decode the returning tag into a one-hot response strobe.
  always_comb begin
    rsp_valid = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      rsp_valid[j] = stage2.valid && (stage2.id == req_id_t'(j));
    end
  end

  assign rsp_data = mem_dout;

`ifdef BRAM_ARB_STATS_EN
  // Count cycles each requester waits with a pending request, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req_valid[j] && !req_ready[j] && (stall_cnt[j*16 +: 16] != 16'hFFFF)) begin
          stall_cnt[j*16 +: 16] <= stall_cnt[j*16 +: 16] + 16'd1;
        end
      end
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Directed bench for bram_rr_arbiter: a 2-requester instance for the
// main scenarios and a 3-requester instance for pointer wrap. Each DUT
// drives a behavioural read-first RAM with a registered read port.
module tb_bram_rr_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // Two-requester instance
  logic [1:0]  r2_valid, r2_we, r2_ready, r2_rsp_valid;
  logic [23:0] r2_addr;
  logic [35:0] r2_wdata;
  logic [17:0] r2_rsp_data, r2_din, r2_dout;
  logic [11:0] r2_raddr, r2_waddr;
  logic        r2_mwe;
  logic [31:0] r2_stall;
  logic [17:0] ram2 [0:4095];

  bram_rr_arbiter #(.WID_MEM(18), .ADDR_W(12), .NUM_REQ(2)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(r2_valid), .req_we(r2_we), .req_addr(r2_addr), .req_wdata(r2_wdata),
    .req_ready(r2_ready), .rsp_valid(r2_rsp_valid), .rsp_data(r2_rsp_data),
    .mem_raddr(r2_raddr), .mem_waddr(r2_waddr), .mem_din(r2_din), .mem_we(r2_mwe),
    .mem_dout(r2_dout), .stall_cnt(r2_stall)
  );

  always @(posedge clk) begin
    if (r2_mwe) ram2[r2_waddr] <= r2_din;
    r2_dout <= ram2[r2_raddr];
  end

  // Three-requester instance
  logic [2:0]  r3_valid, r3_we, r3_ready, r3_rsp_valid;
  logic [35:0] r3_addr;
  logic [53:0] r3_wdata;
  logic [17:0] r3_rsp_data, r3_din, r3_dout;
  logic [11:0] r3_raddr, r3_waddr;
  logic        r3_mwe;
  logic [47:0] r3_stall;
  logic [17:0] ram3 [0:4095];

  bram_rr_arbiter #(.WID_MEM(18), .ADDR_W(12), .NUM_REQ(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(r3_valid), .req_we(r3_we), .req_addr(r3_addr), .req_wdata(r3_wdata),
    .req_ready(r3_ready), .rsp_valid(r3_rsp_valid), .rsp_data(r3_rsp_data),
    .mem_raddr(r3_raddr), .mem_waddr(r3_waddr), .mem_din(r3_din), .mem_we(r3_mwe),
    .mem_dout(r3_dout), .stall_cnt(r3_stall)
  );

  always @(posedge clk) begin
    if (r3_mwe) ram3[r3_waddr] <= r3_din;
    r3_dout <= ram3[r3_raddr];
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] we,
                               input logic [11:0] a0, input logic [11:0] a1,
                               input logic [17:0] d0, input logic [17:0] d1);
    r2_valid = v;
    r2_we    = we;
    r2_addr  = {a1, a0};
    r2_wdata = {d1, d0};
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetPulse();
    reset = 1'b1;
    applyStimulus(2'b00, 2'b00, 12'h0, 12'h0, 18'h0, 18'h0);
    r3_valid = '0;
    nextCycle();
    reset = 1'b0;
  endtask

  logic [1:0] exp2;
  logic [2:0] exp3;

  initial begin
    ram2[12'h010] = 18'h2A5B3;
    ram2[12'h7FF] = 18'h12345;
    ram3[12'h001] = 18'h00001;
    ram3[12'h002] = 18'h00002;
    ram3[12'h003] = 18'h00003;
    r3_valid = '0;
    r3_we    = '0;
    r3_addr  = {12'h003, 12'h002, 12'h001};
    r3_wdata = '0;

    // Reset: requests present but no grants while reset is high
    reset = 1'b1;
    applyStimulus(2'b11, 2'b00, 12'h010, 12'h7FF, 18'h0, 18'h0);
    @(negedge clk);
    checkOutput("ready_in_reset", r2_ready, 2'b00);
    nextCycle();
    @(negedge clk);
    checkOutput("reset_mem_we", r2_mwe, 1'b0);
    checkOutput("reset_rsp_valid", r2_rsp_valid, 2'b00);
    checkOutput("reset_raddr", r2_raddr, 12'h000);
    nextCycle();
    reset = 1'b0;

    // Single uncontended read
    applyStimulus(2'b01, 2'b00, 12'h010, 12'h000, 18'h0, 18'h0);
    @(negedge clk);
    checkOutput("single_ready", r2_ready, 2'b01);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 12'h0, 12'h0, 18'h0, 18'h0);
    @(negedge clk);
    checkOutput("single_raddr", r2_raddr, 12'h010);
    checkOutput("single_rsp_early", r2_rsp_valid, 2'b00);
    nextCycle();
    @(negedge clk);
    checkOutput("single_rsp_valid", r2_rsp_valid, 2'b01);
    checkOutput("single_rsp_data", r2_rsp_data, 18'h2A5B3);
    nextCycle();

    // Both read every cycle from reset: grants alternate 0,1,...
    resetPulse();
    for (int i = 0; i < 8; i++) begin
      if (i < 6) applyStimulus(2'b11, 2'b00, 12'h010, 12'h7FF, 18'h0, 18'h0);
      else       applyStimulus(2'b00, 2'b00, 12'h0, 12'h0, 18'h0, 18'h0);
      @(negedge clk);
      if (i < 6) checkOutput("alt_ready", r2_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i >= 2) begin
        exp2 = ((i - 2) % 2 == 0) ? 2'b01 : 2'b10;
        checkOutput("alt_rsp_valid", r2_rsp_valid, exp2);
        checkOutput("alt_rsp_data", r2_rsp_data, (exp2 == 2'b01) ? 18'h2A5B3 : 18'h12345);
      end else begin
        checkOutput("alt_rsp_idle", r2_rsp_valid, 2'b00);
      end
      nextCycle();
    end

    // Same-cycle write (req0) and read (req1) of 0x7FF, then re-read
    applyStimulus(2'b11, 2'b01, 12'h7FF, 12'h7FF, 18'h3FFFF, 18'h0);
    @(negedge clk);
    checkOutput("haz_ready_both", r2_ready, 2'b11);
    nextCycle();
    applyStimulus(2'b10, 2'b00, 12'h000, 12'h7FF, 18'h0, 18'h0);
    @(negedge clk);
    checkOutput("haz_reread_ready", r2_ready, 2'b10);
    checkOutput("haz_mem_we", r2_mwe, 1'b1);
    checkOutput("haz_mem_waddr", r2_waddr, 12'h7FF);
    checkOutput("haz_mem_din", r2_din, 18'h3FFFF);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 12'h0, 12'h0, 18'h0, 18'h0);
    @(negedge clk);
    checkOutput("haz_we_drop", r2_mwe, 1'b0);
    checkOutput("haz_old_valid", r2_rsp_valid, 2'b10);
    checkOutput("haz_old_data", r2_rsp_data, 18'h12345);
    nextCycle();
    @(negedge clk);
    checkOutput("haz_new_valid", r2_rsp_valid, 2'b10);
    checkOutput("haz_new_data", r2_rsp_data, 18'h3FFFF);
    nextCycle();

    // Reset one cycle after a read grant drops the response
    applyStimulus(2'b11, 2'b10, 12'h010, 12'h020, 18'h0, 18'h11111);
    @(negedge clk);
    checkOutput("rst_grant_ready", r2_ready, 2'b11);
    nextCycle();
    reset = 1'b1;
    applyStimulus(2'b00, 2'b00, 12'h0, 12'h0, 18'h0, 18'h0);
    @(negedge clk);
    checkOutput("rst_we_before", r2_mwe, 1'b1);
    checkOutput("rst_rsp_before", r2_rsp_valid, 2'b00);
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_mem_we", r2_mwe, 1'b0);
    checkOutput("rst_waddr", r2_waddr, 12'h000);
    checkOutput("rst_din", r2_din, 18'h0);
    checkOutput("rst_raddr", r2_raddr, 12'h000);
    checkOutput("rst_rsp_dropped", r2_rsp_valid, 2'b00);
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      @(negedge clk);
      checkOutput("rst_no_rsp", r2_rsp_valid, 2'b00);
    end
    nextCycle();
    applyStimulus(2'b11, 2'b00, 12'h100, 12'h100, 18'h0, 18'h0);
    @(negedge clk);
    checkOutput("rst_first_rd_grant", r2_ready, 2'b01);
    nextCycle();
    applyStimulus(2'b11, 2'b11, 12'h100, 12'h101, 18'h1, 18'h2);
    @(negedge clk);
    checkOutput("rst_first_wr_grant", r2_ready, 2'b01);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 12'h0, 12'h0, 18'h0, 18'h0);
    for (int i = 0; i < 3; i++) nextCycle();

    // Stall counters: ten cycles of both reading gives five stalls each
    resetPulse();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(2'b11, 2'b00, 12'h010, 12'h7FF, 18'h0, 18'h0);
      nextCycle();
    end
    applyStimulus(2'b00, 2'b00, 12'h0, 12'h0, 18'h0, 18'h0);
    @(negedge clk);
`ifdef BRAM_ARB_STATS_EN
    checkOutput("stall_cnt0", r2_stall[15:0], 16'd5);
    checkOutput("stall_cnt1", r2_stall[31:16], 16'd5);
`else
    checkOutput("stall_cnt_off", r2_stall, 32'h0);
`endif
    nextCycle();
    for (int i = 0; i < 3; i++) nextCycle();

    // Pointer wrap with three requesters
    resetPulse();
    for (int i = 0; i < 8; i++) begin
      r3_valid = (i < 6) ? 3'b111 : 3'b000;
      @(negedge clk);
      if (i < 6) checkOutput("wrap_ready", r3_ready, 3'b001 << (i % 3));
      if (i >= 2) begin
        exp3 = 3'b001 << ((i - 2) % 3);
        checkOutput("wrap_rsp_valid", r3_rsp_valid, exp3);
        checkOutput("wrap_rsp_data", r3_rsp_data, 18'((i - 2) % 3 + 1));
      end
      nextCycle();
    end
    r3_valid = 3'b101;
    @(negedge clk);
    checkOutput("wrap_ptr_back_to_0", r3_ready, 3'b001);
    nextCycle();
    r3_valid = 3'b000;
    for (int i = 0; i < 3; i++) nextCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
